// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-wide ripple stage iterated N = WIDTH/DIGIT times,
// with valid/ready handshakes on both the operand and the result side.
module digit_serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                  state_r;
    logic [CW-1:0]               cnt_r;
    logic [N-1:0][DIGIT-1:0]     a_r;
    logic [N-1:0][DIGIT-1:0]     b_r;
    logic [N-1:0][DIGIT-1:0]     sum_r;
    logic                        carry_r;
    logic                        cout_r;
    logic                        ovf_r;
    logic                        zero_r;

    logic [DIGIT-1:0]            a_dig_s;
    logic [DIGIT-1:0]            b_dig_s;
    logic [DIGIT-1:0]            dsum_s;
    logic                        dcarry_s;
    logic                        msb_cin_s;
    logic [N-1:0][DIGIT-1:0]     sum_nx_s;

    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
    endfunction

    // One ripple stage on the current digit; the carry into the MSB is recovered from its sum bit.
    always_comb begin
        a_dig_s             = a_r[cnt_r];
        b_dig_s             = b_r[cnt_r];
        {dcarry_s, dsum_s}  = digit_add(a_dig_s, b_dig_s, carry_r);
        msb_cin_s           = a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1] ^ dsum_s[DIGIT-1];
        sum_nx_s            = sum_r;
        sum_nx_s[cnt_r]     = dsum_s;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + ~cin, so the borrow-in is inverted here.
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? ~cin : cin;
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_r   <= sum_nx_s;
                    carry_r <= dcarry_s;
                    if (cnt_r == LAST) begin
                        cout_r  <= dcarry_s;
                        ovf_r   <= msb_cin_s ^ dcarry_s;
                        zero_r  <= (sum_nx_s == '0);
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: four instances (DIGIT 4, 1, 8, 32) checked by a result scoreboard
// against table vectors, backpressure/reset sequences and a random sweep.
module tb_digit_serial_addsub;

    localparam int NI = 4;
    localparam int DIGS [NI] = '{4, 1, 8, 32};

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   a, b;
    logic          sub, cin, out_ready;
    logic [NI-1:0] iv, rdy, ov, co, of, zr;
    logic [NI-1:0] pv = '0;
    logic [31:0]   sm [NI];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    exp_t          q [NI][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        digit_serial_addsub #(.WIDTH(32), .DIGIT(DIGS[g])) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(rdy[g]),
            .a(a), .b(b), .sub(sub), .cin(cin),
            .out_valid(ov[g]), .out_ready(out_ready),
            .sum(sm[g]), .cout(co[g]), .ovf(of[g]), .zero(zr[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference built from signed/unsigned integer arithmetic, not from the carry chain.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic ms, input logic mc);
        exp_t        e;
        longint      sa, sb, ci, s;
        logic [32:0] t;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ci = longint'({63'd0, mc});
        if (ms) begin
            e.sum  = ma - mb - {31'd0, mc};
            s      = sa - sb - ci;
            e.cout = ({32'd0, ma} >= ({32'd0, mb} + {63'd0, mc}));
        end else begin
            e.sum  = ma + mb + {31'd0, mc};
            s      = sa + sb + ci;
            t      = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
            e.cout = t[32];
        end
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.zero = (e.sum == 32'd0);
        e.acc  = 0;
        return e;
    endfunction

    // Scoreboard: compare each instance's result and latency when out_valid rises.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (ov[i] && !pv[i]) begin
                if (q[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: digit=%0d got valid expected none", DIGS[i]);
                end else begin
                    e = q[i].pop_front();
                    chk($sformatf("result_d%0d", DIGS[i]), {29'd0, sm[i], co[i], of[i], zr[i]},
                        {29'd0, e.sum, e.cout, e.ovf, e.zero});
                    chk($sformatf("latency_d%0d", DIGS[i]), 64'(cyc - e.acc), 64'(32 / DIGS[i]));
                end
            end
            pv[i] <= ov[i];
        end
    end

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NI; i++) n += q[i].size();
        return n;
    endfunction

    task automatic issue(input logic [NI-1:0] mask, input logic [31:0] ta, input logic [31:0] tbv,
                         input logic ts, input logic tc, input logic use_tab, input exp_t te);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (((rdy & mask) != mask) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        if ((rdy & mask) != mask) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: ready=%b expected %b", rdy & mask, mask);
        end
        a = ta; b = tbv; sub = ts; cin = tc; iv = mask;
        e = use_tab ? te : model(ta, tbv, ts, tc);
        e.acc = cyc + 1;
        for (int i = 0; i < NI; i++) if (mask[i]) q[i].push_back(e);
        @(negedge clk);
        iv = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((pending() != 0) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        if (pending() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d expected 0", pending());
            for (int i = 0; i < NI; i++) q[i].delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tv [6];
        exp_t        te;
        exp_t        dummy;
        logic [31:0] ra, rb;
        int          n;

        tv[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tv[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tv[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tv[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0};
        tv[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        tv[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        dummy = '{32'd0, 1'b0, 1'b0, 1'b0, 0};

        iv = '0; a = 32'd0; b = 32'd0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("reset_state_d%0d", DIGS[i]), {28'd0, rdy[i], ov[i], sm[i], co[i], of[i], zr[i]},
                {28'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;

        // Table vectors on every instance.
        for (int k = 0; k < 6; k++) begin
            te = '{tv[k].sum, tv[k].cout, tv[k].ovf, tv[k].zero, 0};
            issue(4'hF, tv[k].a, tv[k].b, tv[k].sub, tv[k].cin, 1'b1, te);
            drain();
        end

        // Backpressure: result held while in_valid and operands wiggle.
        out_ready = 1'b0;
        te = '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0};
        issue(4'b0001, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, te);
        n = 0;
        while (!ov[0] && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", {63'd0, ov[0]}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            iv[0] = ~iv[0];
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp_hold", {28'd0, rdy[0], ov[0], sm[0], co[0], of[0], zr[0]},
                {28'd0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        end
        iv = '0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {62'd0, ov[0], rdy[0]}, {62'd0, 1'b0, 1'b1});
        drain();

        // Reset in the middle of RUN (digit 3 in progress).
        te = '{32'h2345_6789, 1'b0, 1'b0, 1'b0, 0};
        issue(4'b0001, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, te);
        repeat (3) @(negedge clk);
        chk("midrun_partial", {52'd0, sm[0][11:0]}, {52'd0, 12'h789});
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", {28'd0, rdy[0], ov[0], sm[0], co[0], of[0], zr[0]},
            {28'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0});
        q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'b0001, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, te);
        drain();

        // Random sweep against the model, all widths in lockstep.
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            if ((k % 8) == 0) ra = (k % 16 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            if ((k % 12) == 0) rb = ra;
            issue(4'hF, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, dummy);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised, multi-cycle adder/subtractor for the division datapath. It processes WIDTH-bit operands DIGIT bits per clock, least-significant digit first, using one DIGIT-wide ripple stage and a carry register. It returns sum, carry, signed-overflow and zero flags. Operands are taken through a valid/ready handshake and results are returned through a second one, so the divider control can trade area for latency by choosing DIGIT.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle. N = WIDTH/DIGIT is the number of run cycles; N ≥ 1.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- sub  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in for add, borrow-in for subtract.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB.
- ovf  out  1  two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- States: IDLE, RUN and DONE. A digit counter of clog2(N) bits, minimum 1, runs from 0 to N−1.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a into the operand register.
  - Latch the effective B: b when sub = 0, ~b when sub = 1.
  - Set the carry register to cin when sub = 0, and to ~cin when sub = 1.
  - Clear the counter and go to RUN.
- Arithmetic:
  - Add computes a + b + cin.
  - Subtract computes a − b − cin, implemented as a + ~b + ~cin.
  - Results are modulo 2^WIDTH.
- RUN, each cycle:
  - Add digit k of A, digit k of effective B and the carry register.
  - Write the DIGIT-bit result into digit k of the sum register and store the digit carry-out.
  - On the last digit (k = N−1):
    - cout = carry out of bit WIDTH−1.
    - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
    - zero = (whole final sum == 0).
    - Go to DONE.
- DONE:
  - out_valid = 1.
  - sum, cout, ovf and zero are held stable until out_valid & out_ready.
  - On that handshake, go to IDLE. out_valid drops the next cycle.
- in_valid is ignored in RUN and DONE. The block never overlaps a new operation with a pending result.
- Operand registers do not change outside the IDLE accept.
- Subtract flag meanings:
  - cout = 1 means no borrow.
  - ovf = 1 means the signed result is unrepresentable.

## Timing
- Reset (asynchronous, rst_n low):
  - State goes to IDLE immediately.
  - in_ready = 1, out_valid = 0.
  - sum = 0, cout = 0, ovf = 0, zero = 0.
  - Counter and carry register = 0.
- Reset mid-operation discards the operation; no partial result is ever flagged valid.
- Latency:
  - Accept on edge E0.
  - Digit i is written on edge E(i+1).
  - out_valid is high after edge EN, i.e. N cycles after accept.
  - With DIGIT = WIDTH, latency is 1.
- Throughput: one operation per N+2 cycles at best: accept, N run cycles, one DONE cycle, then back to IDLE before the next accept.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- out_ready held high before DONE: the result is still presented for at least one cycle.

## Test plan
Defaults: WIDTH=32, DIGIT=4, N=8.
- Add carry and zero: add, a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, zero=1; out_valid rises exactly 8 cycles after accept.
- Subtract with overflow: sub, a=0x80000000, b=0x00000001, cin=0 -> sum=0x7FFFFFFF, cout=1, ovf=1, zero=0.
- Add with overflow: add, a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- Subtract with borrow: sub, a=5, b=7, cin=1 -> sum=0xFFFFFFFD, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands -> outputs unchanged, in_ready=0, no new accept. Then raise out_ready -> out_valid falls next cycle and in_ready=1.
- Reset mid-run: drop rst_n during RUN digit 3 -> outputs zero immediately and in_ready=1. After release, add 0x12345678+0x11111111 -> sum=0x23456789.
- Sweep DIGIT ∈ {1, 8, 32}: 1000 random operands, checked against a reference model, with latencies of 32, 4 and 1 respectively.
